mem_seq_initiator: RTL and testbench
====================================

Name: mem_seq_initiator

Overview:
- Initiator-side sequencer for the 32-bit single-word valid/ready memory interface.
- Takes a command: base address, word count, op, seed. Issues one word transaction at a time to a memory responder.
- Fill writes data seed+i; check reads back and compares against seed+i.
- Reports error responses, data mismatches, first failing address and timeout. Used for memory init/BIST and as a bus master for bring-up.

Parameters:
ADDR_W, 32, width of memory address (word addressed; out-of-range addresses are legal requests)
LEN_W, 16, width of transfer length
CNT_W, 16, width of error/mismatch counters (saturating)
TIMEOUT_CYC, 64, max WAIT cycles for ready before abort (>=2)
ABORT_ON_ERR, 0, 1 = stop sequence on first error response

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
cmd_valid  in  1  command request
cmd_ready  out  1  high in IDLE only
cmd_op  in  1  1 = fill (write), 0 = check (read); same polarity as wr_rd
cmd_base  in  ADDR_W  first word address
cmd_len  in  LEN_W  number of words
cmd_seed  in  32  pattern seed
valid  out  1  memory request, one-cycle pulse per transaction
wr_rd  out  1  1 = write, 0 = read
addr  out  ADDR_W  request address
wdata  out  32  write data
rdata  in  32  read data, qualified by ready
ready  in  1  responder completion pulse
error  in  1  responder error, qualified by ready
busy  out  1  sequence in progress
done  out  1  one-cycle pulse at sequence end
err_cnt  out  CNT_W  error responses seen
mis_cnt  out  CNT_W  read-data mismatches
first_fail_addr  out  ADDR_W  address of first error or mismatch
fail_seen  out  1  first_fail_addr valid
timeout  out  1  sequence aborted on timeout

Behaviour:
- Reset: synchronous, active-low, all outputs 0, state IDLE. Reset mid-sequence drops valid the same edge; in-flight response is ignored.
- IDLE:
  - cmd_ready=1.
  - cmd_valid at an edge latches op/base/len/seed, clears idx and all status (err_cnt, mis_cnt, fail_seen, first_fail_addr, timeout), sets busy.
  - Go to REQ, or to DONE if len==0.
- REQ:
  - valid=1 for exactly one cycle.
  - addr=base+idx (mod 2^ADDR_W); wr_rd=op; wdata=seed+idx (32-bit wrap; 0 on reads).
  - Go to WAIT.
  - valid is never high two consecutive cycles, because the responder executes once per sampled valid.
- WAIT:
  - valid=0; addr/wr_rd/wdata held.
  - On ready:
    - If error=1: err_cnt++ and no data compare.
    - Else if read and rdata != seed+idx: mis_cnt++.
    - On the first failure of either kind: capture addr into first_fail_addr and set fail_seen.
    - Then idx++. Go to DONE if idx==len, or if ABORT_ON_ERR and error. Otherwise go to REQ.
  - Timeout counter clears on entry. If it reaches TIMEOUT_CYC without ready: timeout=1, go to DONE.
- DONE: done=1 for one cycle, busy=0 on exit, then IDLE. Status holds until the next accepted command.
- Counters saturate at 2^CNT_W-1.
- ready outside WAIT (IDLE/REQ/DONE) is ignored.
- cmd_valid while busy is ignored (cmd_ready=0).
- Latency:
  - Responder with one-cycle ready: 2 cycles per word.
  - Accept edge to done pulse = 2*len+1 cycles; done is high in the cycle after the last ready.
- Address wrap past 2^ADDR_W-1 continues at 0. Addresses beyond the responder range are issued as normal and produce error responses.

Decomposition:
- Package mem_seq_pkg: state enum (IDLE, REQ, WAIT, DONE), OP_FILL=1'b1 / OP_CHECK=1'b0 constants, expected-data function seed+idx.
- Sub-module mem_seq_timer: loadable WAIT-cycle counter with clear/enable inputs and expired output.

Test Plan:
- Fill then check, base=0, len=16, seed=32'hA5A5_0000 -> 16 writes at addr 0..15 with wdata A5A5_0000..A5A5_000F; check: done after 33 cycles, err_cnt=0, mis_cnt=0, fail_seen=0.
- Check with responder corrupting addr 5 (rdata^1), base=0, len=8 -> mis_cnt=1, first_fail_addr=5, fail_seen=1, all 8 reads issued.
- Fill base=1020, len=8, ABORT_ON_ERR=0 -> err_cnt=4, first_fail_addr=1024; with ABORT_ON_ERR=1 -> err_cnt=1, 5 transactions issued, done asserted.
- Responder never asserts ready -> timeout=1 after 64 WAIT cycles, done pulse, valid high only once.
- len=0 -> no valid pulses; done 1 cycle after accept; counters 0.
- rst_n low for one cycle during WAIT of word 3 -> next edge: valid=0, busy=0, all status 0, cmd_ready=1; a late ready is ignored and a new command runs cleanly.

Source files
------------

// File: rtl/mem_seq_pkg.sv
// Shared definitions for the memory sequencer: FSM state encodings,
// operation codes and the expected-data pattern generator.
package mem_seq_pkg;

  // FSM state encoding (plain constants so older tools can consume them)
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_REQ  = 2'd1;
  localparam state_t ST_WAIT = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  // Operation codes, same polarity as the bus wr_rd signal
  localparam logic OP_FILL  = 1'b1;
  localparam logic OP_CHECK = 1'b0;

  // Data pattern for word idx of a sequence: seed + idx with 32-bit wrap
  function automatic logic [31:0] exp_data(input logic [31:0] seed,
                                           input logic [31:0] idx);
    return seed + idx;
  endfunction

endpackage

// File: rtl/mem_seq_initiator_if.sv
// Single-word valid/ready memory bus between the sequencer (master)
// and a memory responder (slave). ready qualifies rdata and error.
interface mem_seq_initiator_if #(
  parameter int ADDR_W = 32
) ();

  logic              valid;
  logic              wr_rd;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              ready;
  logic              error;

  modport master (
    output valid, wr_rd, addr, wdata,
    input  rdata, ready, error
  );

  modport slave (
    input  valid, wr_rd, addr, wdata,
    output rdata, ready, error
  );

endinterface

// File: rtl/mem_seq_timer.sv
// WAIT-cycle watchdog. Cleared while a request is being issued, counts
// every cycle the sequencer waits without a response and flags expiry
// on the TIMEOUT_CYC-th such cycle.
module mem_seq_timer #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Expiry is combinational so the FSM leaves WAIT on exactly the limit cycle
  assign expired_o = en_i && (cnt_q == CW'(TIMEOUT_CYC - 1));

  // Next count: clear has priority, count stops once expired
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_seq_initiator.sv
// Memory fill/check sequencer. Accepts a command (op, base, len, seed),
// issues one single-word bus transaction at a time and accumulates
// error-response, data-mismatch, first-failure and timeout status.
module mem_seq_initiator
  import mem_seq_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int LEN_W        = 16,
  parameter int CNT_W        = 16,
  parameter int TIMEOUT_CYC  = 64,
  parameter bit ABORT_ON_ERR = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  // command side
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [31:0]       cmd_seed,
  // memory bus
  mem_seq_initiator_if.master bus,
  // status
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]  mis_cnt,
  output logic [ADDR_W-1:0] first_fail_addr,
  output logic              fail_seen,
  output logic              timeout
);

  state_t            state_q, state_d;
  logic              op_q, op_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [31:0]       seed_q, seed_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0]  mis_cnt_q, mis_cnt_d;
  logic [ADDR_W-1:0] ffa_q, ffa_d;
  logic              fail_seen_q, fail_seen_d;
  logic              timeout_q, timeout_d;

  logic              timer_clr;
  logic              timer_en;
  logic              timer_expired;
  logic [LEN_W-1:0]  idx_inc;
  logic              rd_mismatch;
  logic              word_fail;

  mem_seq_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (timer_clr),
    .en_i      (timer_en),
    .expired_o (timer_expired)
  );

  assign idx_inc     = idx_q + 1'b1;
  // Data compare only applies to clean read responses
  assign rd_mismatch = (op_q == OP_CHECK) && !bus.error &&
                       (bus.rdata != exp_data(seed_q, 32'(idx_q)));
  assign word_fail   = bus.error || rd_mismatch;

  // Outputs decoded from state; bus address/data come from held registers
  assign cmd_ready       = (state_q == ST_IDLE);
  assign busy            = (state_q != ST_IDLE);
  assign done            = (state_q == ST_DONE);
  assign bus.valid       = (state_q == ST_REQ);
  assign bus.wr_rd       = op_q;
  assign bus.addr        = addr_q;
  assign bus.wdata       = wdata_q;
  assign err_cnt         = err_cnt_q;
  assign mis_cnt         = mis_cnt_q;
  assign first_fail_addr = ffa_q;
  assign fail_seen       = fail_seen_q;
  assign timeout         = timeout_q;

  // Sequencer next-state: command accept, request issue, response handling
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    base_d      = base_q;
    len_d       = len_q;
    seed_d      = seed_q;
    idx_d       = idx_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    err_cnt_d   = err_cnt_q;
    mis_cnt_d   = mis_cnt_q;
    ffa_d       = ffa_q;
    fail_seen_d = fail_seen_q;
    timeout_d   = timeout_q;
    timer_clr   = 1'b0;
    timer_en    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d        = cmd_op;
          base_d      = cmd_base;
          len_d       = cmd_len;
          seed_d      = cmd_seed;
          idx_d       = '0;
          err_cnt_d   = '0;
          mis_cnt_d   = '0;
          ffa_d       = '0;
          fail_seen_d = 1'b0;
          timeout_d   = 1'b0;
          // First request is prepared here so addr/wdata are stable with valid
          addr_d      = cmd_base;
          wdata_d     = (cmd_op == OP_FILL) ? cmd_seed : 32'd0;
          state_d     = (cmd_len == '0) ? ST_DONE : ST_REQ;
        end
      end

      ST_REQ: begin
        // Single-cycle valid; watchdog restarts for the coming WAIT
        timer_clr = 1'b1;
        state_d   = ST_WAIT;
      end

      ST_WAIT: begin
        timer_en = !bus.ready;
        if (bus.ready) begin
          if (bus.error && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 1'b1;
          end
          if (rd_mismatch && (mis_cnt_q != '1)) begin
            mis_cnt_d = mis_cnt_q + 1'b1;
          end
          if (word_fail && !fail_seen_q) begin
            ffa_d       = addr_q;
            fail_seen_d = 1'b1;
          end
          idx_d = idx_inc;
          if ((idx_inc == len_q) || (ABORT_ON_ERR && bus.error)) begin
            state_d = ST_DONE;
          end else begin
            // base + idx advances one word; wraps naturally at 2^ADDR_W
            addr_d  = addr_q + 1'b1;
            wdata_d = (op_q == OP_FILL) ? exp_data(seed_q, 32'(idx_inc)) : 32'd0;
            state_d = ST_REQ;
          end
        end else if (timer_expired) begin
          timeout_d = 1'b1;
          state_d   = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and status registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= 1'b0;
      base_q      <= '0;
      len_q       <= '0;
      seed_q      <= '0;
      idx_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      err_cnt_q   <= '0;
      mis_cnt_q   <= '0;
      ffa_q       <= '0;
      fail_seen_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      base_q      <= base_d;
      len_q       <= len_d;
      seed_q      <= seed_d;
      idx_q       <= idx_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      err_cnt_q   <= err_cnt_d;
      mis_cnt_q   <= mis_cnt_d;
      ffa_q       <= ffa_d;
      fail_seen_q <= fail_seen_d;
      timeout_q   <= timeout_d;
    end
  end

endmodule

// File: tb/tb_mem_seq_initiator.sv
// Directed bench for mem_seq_initiator: two instances (continue-on-error
// and abort-on-error) each behind a 1024-word one-cycle-ready responder.
module tb_mem_seq_initiator;
  import mem_seq_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // main instance (ABORT_ON_ERR=0)
  logic        m_cmd_valid = 1'b0, m_cmd_op = 1'b0;
  logic [31:0] m_cmd_base = '0, m_cmd_seed = '0;
  logic [15:0] m_cmd_len = '0;
  logic        m_cmd_ready, m_busy, m_done, m_fail_seen, m_timeout;
  logic [15:0] m_err_cnt, m_mis_cnt;
  logic [31:0] m_ffa;
  mem_seq_initiator_if #(.ADDR_W(32)) m_if ();

  mem_seq_initiator #(.ADDR_W(32), .LEN_W(16), .CNT_W(16), .TIMEOUT_CYC(64), .ABORT_ON_ERR(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(m_cmd_valid), .cmd_ready(m_cmd_ready), .cmd_op(m_cmd_op),
    .cmd_base(m_cmd_base), .cmd_len(m_cmd_len), .cmd_seed(m_cmd_seed), .bus(m_if),
    .busy(m_busy), .done(m_done), .err_cnt(m_err_cnt), .mis_cnt(m_mis_cnt),
    .first_fail_addr(m_ffa), .fail_seen(m_fail_seen), .timeout(m_timeout));

  // abort-on-error instance
  logic        a_cmd_valid = 1'b0, a_cmd_op = 1'b0;
  logic [31:0] a_cmd_base = '0, a_cmd_seed = '0;
  logic [15:0] a_cmd_len = '0;
  logic        a_cmd_ready, a_busy, a_done, a_fail_seen, a_timeout;
  logic [15:0] a_err_cnt, a_mis_cnt;
  logic [31:0] a_ffa;
  mem_seq_initiator_if #(.ADDR_W(32)) a_if ();

  mem_seq_initiator #(.ADDR_W(32), .LEN_W(16), .CNT_W(16), .TIMEOUT_CYC(64), .ABORT_ON_ERR(1'b1)) dut_ab (
    .clk(clk), .rst_n(rst_n), .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready), .cmd_op(a_cmd_op),
    .cmd_base(a_cmd_base), .cmd_len(a_cmd_len), .cmd_seed(a_cmd_seed), .bus(a_if),
    .busy(a_busy), .done(a_done), .err_cnt(a_err_cnt), .mis_cnt(a_mis_cnt),
    .first_fail_addr(a_ffa), .fail_seen(a_fail_seen), .timeout(a_timeout));

  // responder controls
  bit          no_ready = 1'b0;
  bit          corrupt_en = 1'b0;
  bit          inject_ready = 1'b0;
  logic [31:0] corrupt_addr = '0;
  logic [31:0] mem [0:1023];

  // main responder: 1024 words, error beyond, ready one cycle after valid
  always @(posedge clk) begin
    m_if.ready <= 1'b0;
    m_if.error <= 1'b0;
    m_if.rdata <= '0;
    if (inject_ready) begin
      m_if.ready <= 1'b1;
      m_if.error <= 1'b1;
    end else if (m_if.valid && !no_ready) begin
      m_if.ready <= 1'b1;
      if (m_if.addr >= 32'd1024) m_if.error <= 1'b1;
      else if (m_if.wr_rd) mem[m_if.addr[9:0]] <= m_if.wdata;
      else m_if.rdata <= mem[m_if.addr[9:0]] ^ ((corrupt_en && m_if.addr == corrupt_addr) ? 32'd1 : 32'd0);
    end
  end

  // abort-instance responder: status only, no storage
  always @(posedge clk) begin
    a_if.ready <= a_if.valid && !no_ready;
    a_if.error <= a_if.valid && !no_ready && (a_if.addr >= 32'd1024);
    a_if.rdata <= '0;
  end

  logic [31:0] log_addr  [0:63];
  logic [31:0] log_wdata [0:63];
  logic        log_wr    [0:63];

  // Issue one command, record bus requests, count edges (accept edge = 1) to done
  task automatic run_cmd(input bit sel, input logic op, input logic [31:0] base,
                         input logic [15:0] len, input logic [31:0] seed,
                         output int cycles, output int nvalid);
    logic v, d;
    logic [31:0] a, w;
    logic wr;
    cycles = 0;
    nvalid = 0;
    @(negedge clk);
    if (sel) begin
      a_cmd_valid = 1'b1; a_cmd_op = op; a_cmd_base = base; a_cmd_len = len; a_cmd_seed = seed;
    end else begin
      m_cmd_valid = 1'b1; m_cmd_op = op; m_cmd_base = base; m_cmd_len = len; m_cmd_seed = seed;
    end
    while (cycles < 500) begin
      @(negedge clk);
      m_cmd_valid = 1'b0;
      a_cmd_valid = 1'b0;
      cycles++;
      v  = sel ? a_if.valid : m_if.valid;
      d  = sel ? a_done : m_done;
      a  = sel ? a_if.addr : m_if.addr;
      w  = sel ? a_if.wdata : m_if.wdata;
      wr = sel ? a_if.wr_rd : m_if.wr_rd;
      if (v) begin
        if (nvalid < 64) begin
          log_addr[nvalid] = a; log_wdata[nvalid] = w; log_wr[nvalid] = wr;
        end
        $display("txn dut=%0d #%0d %s addr=%08h wdata=%08h", sel, nvalid, wr ? "WR" : "RD", a, w);
        nvalid++;
      end
      if (d) break;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (m_if.valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", m_if.valid); end
    checks++; if (m_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", m_busy); end
    checks++; if (m_done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", m_done); end
    checks++; if (m_cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready got %b exp 1", m_cmd_ready); end
    checks++; if (m_err_cnt !== 16'd0 || m_mis_cnt !== 16'd0) begin errors++; $display("FAIL rst_cnt got %0d/%0d exp 0/0", m_err_cnt, m_mis_cnt); end
    checks++; if (m_ffa !== 32'd0 || m_fail_seen !== 1'b0 || m_timeout !== 1'b0) begin errors++; $display("FAIL rst_status got ffa=%h fs=%b to=%b exp 0", m_ffa, m_fail_seen, m_timeout); end
    checks++; if (m_if.addr !== 32'd0 || m_if.wdata !== 32'd0 || m_if.wr_rd !== 1'b0) begin errors++; $display("FAIL rst_bus got addr=%h wdata=%h wr=%b exp 0", m_if.addr, m_if.wdata, m_if.wr_rd); end
    rst_n = 1'b1;
  endtask

  task automatic test_fill_check();
    int cyc, nv;
    run_cmd(1'b0, OP_FILL, 32'd0, 16'd16, 32'hA5A5_0000, cyc, nv);
    checks++; if (cyc !== 33) begin errors++; $display("FAIL fill_latency got %0d exp 33", cyc); end
    checks++; if (nv !== 16) begin errors++; $display("FAIL fill_nvalid got %0d exp 16", nv); end
    for (int i = 0; i < 16 && i < nv; i++) begin
      checks++; if (log_addr[i] !== 32'(i) || log_wdata[i] !== 32'hA5A5_0000 + 32'(i) || log_wr[i] !== 1'b1) begin
        errors++; $display("FAIL fill_txn%0d got addr=%h wdata=%h wr=%b exp addr=%h wdata=%h wr=1", i, log_addr[i], log_wdata[i], log_wr[i], i, 32'hA5A5_0000 + 32'(i)); end
    end
    checks++; if (m_err_cnt !== 16'd0 || m_mis_cnt !== 16'd0 || m_fail_seen !== 1'b0) begin errors++; $display("FAIL fill_status got err=%0d mis=%0d fs=%b exp 0/0/0", m_err_cnt, m_mis_cnt, m_fail_seen); end
    run_cmd(1'b0, OP_CHECK, 32'd0, 16'd16, 32'hA5A5_0000, cyc, nv);
    checks++; if (cyc !== 33) begin errors++; $display("FAIL check_latency got %0d exp 33", cyc); end
    checks++; if (nv !== 16) begin errors++; $display("FAIL check_nvalid got %0d exp 16", nv); end
    for (int i = 0; i < 16 && i < nv; i++) begin
      checks++; if (log_addr[i] !== 32'(i) || log_wdata[i] !== 32'd0 || log_wr[i] !== 1'b0) begin
        errors++; $display("FAIL check_txn%0d got addr=%h wdata=%h wr=%b exp addr=%h wdata=0 wr=0", i, log_addr[i], log_wdata[i], log_wr[i], i); end
    end
    checks++; if (m_err_cnt !== 16'd0 || m_mis_cnt !== 16'd0 || m_fail_seen !== 1'b0 || m_timeout !== 1'b0) begin errors++; $display("FAIL check_status got err=%0d mis=%0d fs=%b to=%b exp 0", m_err_cnt, m_mis_cnt, m_fail_seen, m_timeout); end
  endtask

  task automatic test_mismatch();
    int cyc, nv;
    corrupt_en = 1'b1;
    corrupt_addr = 32'd5;
    run_cmd(1'b0, OP_CHECK, 32'd0, 16'd8, 32'hA5A5_0000, cyc, nv);
    corrupt_en = 1'b0;
    checks++; if (nv !== 8) begin errors++; $display("FAIL mis_nvalid got %0d exp 8", nv); end
    checks++; if (cyc !== 17) begin errors++; $display("FAIL mis_latency got %0d exp 17", cyc); end
    checks++; if (m_mis_cnt !== 16'd1) begin errors++; $display("FAIL mis_cnt got %0d exp 1", m_mis_cnt); end
    checks++; if (m_err_cnt !== 16'd0) begin errors++; $display("FAIL mis_err_cnt got %0d exp 0", m_err_cnt); end
    checks++; if (m_ffa !== 32'd5 || m_fail_seen !== 1'b1) begin errors++; $display("FAIL mis_ffa got %h fs=%b exp 5 fs=1", m_ffa, m_fail_seen); end
  endtask

  task automatic test_len0();
    int cyc, nv;
    run_cmd(1'b0, OP_FILL, 32'd123, 16'd0, 32'h1234_5678, cyc, nv);
    checks++; if (cyc !== 1) begin errors++; $display("FAIL len0_latency got %0d exp 1", cyc); end
    checks++; if (nv !== 0) begin errors++; $display("FAIL len0_nvalid got %0d exp 0", nv); end
    checks++; if (m_err_cnt !== 16'd0 || m_mis_cnt !== 16'd0 || m_fail_seen !== 1'b0 || m_ffa !== 32'd0) begin
      errors++; $display("FAIL len0_status got err=%0d mis=%0d fs=%b ffa=%h exp all 0", m_err_cnt, m_mis_cnt, m_fail_seen, m_ffa); end
  endtask

  task automatic test_abort();
    int cyc, nv;
    run_cmd(1'b0, OP_FILL, 32'd1020, 16'd8, 32'h0000_1000, cyc, nv);
    checks++; if (nv !== 8 || cyc !== 17) begin errors++; $display("FAIL noabort_txns got nv=%0d cyc=%0d exp 8/17", nv, cyc); end
    checks++; if (m_err_cnt !== 16'd4) begin errors++; $display("FAIL noabort_err_cnt got %0d exp 4", m_err_cnt); end
    checks++; if (m_ffa !== 32'd1024 || m_fail_seen !== 1'b1 || m_mis_cnt !== 16'd0) begin errors++; $display("FAIL noabort_ffa got %h fs=%b mis=%0d exp 1024 fs=1 mis=0", m_ffa, m_fail_seen, m_mis_cnt); end
    run_cmd(1'b1, OP_FILL, 32'd1020, 16'd8, 32'h0000_1000, cyc, nv);
    checks++; if (nv !== 5) begin errors++; $display("FAIL abort_nvalid got %0d exp 5", nv); end
    checks++; if (cyc !== 11) begin errors++; $display("FAIL abort_latency got %0d exp 11", cyc); end
    checks++; if (a_err_cnt !== 16'd1) begin errors++; $display("FAIL abort_err_cnt got %0d exp 1", a_err_cnt); end
    checks++; if (a_ffa !== 32'd1024 || a_fail_seen !== 1'b1 || a_timeout !== 1'b0) begin errors++; $display("FAIL abort_status got ffa=%h fs=%b to=%b exp 1024 1 0", a_ffa, a_fail_seen, a_timeout); end
  endtask

  task automatic test_wrap();
    int cyc, nv;
    logic [31:0] exp_a [0:3];
    exp_a[0] = 32'hFFFF_FFFE; exp_a[1] = 32'hFFFF_FFFF; exp_a[2] = 32'h0; exp_a[3] = 32'h1;
    run_cmd(1'b0, OP_FILL, 32'hFFFF_FFFE, 16'd4, 32'hA5A4_FFFE, cyc, nv);
    checks++; if (nv !== 4 || cyc !== 9) begin errors++; $display("FAIL wrap_txns got nv=%0d cyc=%0d exp 4/9", nv, cyc); end
    for (int i = 0; i < 4 && i < nv; i++) begin
      checks++; if (log_addr[i] !== exp_a[i] || log_wdata[i] !== 32'hA5A4_FFFE + 32'(i)) begin
        errors++; $display("FAIL wrap_txn%0d got addr=%h wdata=%h exp addr=%h wdata=%h", i, log_addr[i], log_wdata[i], exp_a[i], 32'hA5A4_FFFE + 32'(i)); end
    end
    checks++; if (m_err_cnt !== 16'd2 || m_ffa !== 32'hFFFF_FFFE) begin errors++; $display("FAIL wrap_status got err=%0d ffa=%h exp 2 fffffffe", m_err_cnt, m_ffa); end
  endtask

  task automatic test_timeout();
    int cyc, nv;
    no_ready = 1'b1;
    run_cmd(1'b0, OP_FILL, 32'd0, 16'd4, 32'd0, cyc, nv);
    no_ready = 1'b0;
    checks++; if (cyc !== 66) begin errors++; $display("FAIL to_latency got %0d exp 66", cyc); end
    checks++; if (nv !== 1) begin errors++; $display("FAIL to_nvalid got %0d exp 1", nv); end
    checks++; if (m_timeout !== 1'b1) begin errors++; $display("FAIL to_flag got %b exp 1", m_timeout); end
    checks++; if (m_err_cnt !== 16'd0 || m_fail_seen !== 1'b0) begin errors++; $display("FAIL to_status got err=%0d fs=%b exp 0 0", m_err_cnt, m_fail_seen); end
  endtask

  task automatic test_reset_mid();
    int nv, cyc, guard;
    nv = 0;
    guard = 0;
    @(negedge clk);
    m_cmd_valid = 1'b1; m_cmd_op = OP_FILL; m_cmd_base = 32'd1022; m_cmd_len = 16'd8; m_cmd_seed = 32'h7000_0000;
    while (nv < 4 && guard < 100) begin
      @(negedge clk);
      m_cmd_valid = 1'b0;
      guard++;
      if (m_if.valid) nv++;
    end
    no_ready = 1'b1;
    checks++; if (nv !== 4) begin errors++; $display("FAIL mid_reach_word3 got %0d exp 4", nv); end
    @(negedge clk);
    checks++; if (m_busy !== 1'b1 || m_err_cnt !== 16'd1) begin errors++; $display("FAIL mid_pre got busy=%b err=%0d exp 1 1", m_busy, m_err_cnt); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (m_if.valid !== 1'b0 || m_busy !== 1'b0 || m_cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ctrl got valid=%b busy=%b rdy=%b exp 0 0 1", m_if.valid, m_busy, m_cmd_ready); end
    checks++; if (m_err_cnt !== 16'd0 || m_ffa !== 32'd0 || m_fail_seen !== 1'b0 || m_timeout !== 1'b0) begin
      errors++; $display("FAIL mid_rst_status got err=%0d ffa=%h fs=%b to=%b exp 0", m_err_cnt, m_ffa, m_fail_seen, m_timeout); end
    inject_ready = 1'b1;
    @(negedge clk);
    inject_ready = 1'b0;
    @(negedge clk);
    checks++; if (m_err_cnt !== 16'd0 || m_busy !== 1'b0 || m_cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_late_ready got err=%0d busy=%b rdy=%b exp 0 0 1", m_err_cnt, m_busy, m_cmd_ready); end
    no_ready = 1'b0;
    run_cmd(1'b0, OP_CHECK, 32'd0, 16'd4, 32'hA5A5_0000, cyc, nv);
    checks++; if (cyc !== 9 || nv !== 4) begin errors++; $display("FAIL mid_rerun got cyc=%0d nv=%0d exp 9 4", cyc, nv); end
    checks++; if (m_err_cnt !== 16'd0 || m_mis_cnt !== 16'd0 || m_fail_seen !== 1'b0) begin errors++; $display("FAIL mid_rerun_status got err=%0d mis=%0d fs=%b exp 0", m_err_cnt, m_mis_cnt, m_fail_seen); end
  endtask

  initial begin
    test_reset();
    test_fill_check();
    test_mismatch();
    test_len0();
    test_abort();
    test_wrap();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no finish exp finish");
    $fatal(1, "watchdog");
  end

endmodule
